// File: rtl/sram_ctrl.sv
// sram_ctrl: bus-side initiator for the 8-bit asynchronous SRAM (512 KiB).
// Turns single-byte read/write requests into timed CE#/OE#/WE# sequences.
// Each access runs SETUP -> ACCESS -> HOLD -> RECOVER, and only one access
// is in flight at a time. Every pin output is a flop, so there is no
// combinational path from the request inputs to the pads.

`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

module sram_ctrl #(
    parameter int unsigned RD_WAIT = 2,  // OE# low cycles per read, 1..15
    parameter int unsigned WR_WAIT = 2,  // WE# low cycles per write, 1..15
    parameter int unsigned TURN    = 1   // CE# high idle cycles after an access, 0..7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        we,
    input  logic [18:0] addr,
    input  logic [7:0]  wdata,
    output logic        rdy,
    output logic        resp,
    output logic [7:0]  rdata,
    output logic        sram_ce_bar,
    output logic        sram_oe_bar,
    output logic        sram_we_bar,
    output logic        sram_data_dir,
    output logic [7:0]  sram_data_out,
    input  logic [7:0]  sram_data_in,
    output logic [18:0] sram_addr
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RECOVER
    } state_t;

    localparam logic [3:0] RD_CNT   = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT   = 4'(WR_WAIT);
    localparam logic [3:0] TURN_CNT = 4'(TURN);

    state_t     state;
    logic       write_op;   // direction of the access in flight
    logic [3:0] wait_cnt;   // shared down-counter for ACCESS and RECOVER

    // The controller is ready exactly when it is idle.
    assign rdy = (state == IDLE);

    // The pin values for the next cycle are set on the edge that enters that
    // cycle's state, so each pin toggles in the same cycle its state begins.
    // The counter is only decremented while above 1, so it can never wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            write_op      <= 1'b0;
            wait_cnt      <= 4'd0;
            resp          <= 1'b0;
            rdata         <= 8'd0;
            sram_ce_bar   <= 1'b1;
            sram_oe_bar   <= 1'b1;
            sram_we_bar   <= 1'b1;
            sram_data_dir <= `IOR_DIR_IN;
            sram_data_out <= 8'd0;
            sram_addr     <= 19'd0;
        end else begin
            resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        // Capture the operands; address and write data
                        // reach the pads before either strobe falls.
                        write_op    <= we;
                        sram_addr   <= addr;
                        sram_ce_bar <= 1'b0;
                        if (we) begin
                            sram_data_dir <= `IOR_DIR_OUT;
                            sram_data_out <= wdata;
                        end else begin
                            sram_data_dir <= `IOR_DIR_IN;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    // Only one strobe is lowered, and CE# is already low.
                    if (write_op) begin
                        wait_cnt    <= WR_CNT;
                        sram_we_bar <= 1'b0;
                    end else begin
                        wait_cnt    <= RD_CNT;
                        sram_oe_bar <= 1'b0;
                    end
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt <= 4'd1) begin
                        // Last strobe cycle: sample read data while OE# is
                        // still low, then raise both strobes for the hold cycle.
                        if (!write_op) begin
                            rdata <= sram_data_in;
                        end
                        sram_oe_bar <= 1'b1;
                        sram_we_bar <= 1'b1;
                        resp        <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    // Address and data have now been held for one cycle past
                    // the strobe; release the chip and the data pads.
                    sram_ce_bar   <= 1'b1;
                    sram_data_dir <= `IOR_DIR_IN;
                    if (TURN_CNT != 4'd0) begin
                        wait_cnt <= TURN_CNT;
                        state    <= RECOVER;
                    end else begin
                        state <= IDLE;
                    end
                end
                RECOVER: begin
                    if (wait_cnt <= 4'd1) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl. Table-driven transactions,
// hand-written corner sequences, a behavioural SRAM model, a cycle-accurate
// pin model keyed on the accept cycle, and a response scoreboard queue.

`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

module tb_sram_ctrl;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam int TURN    = 1;
    localparam logic DIR_OUT = `IOR_DIR_OUT;
    localparam logic DIR_IN  = `IOR_DIR_IN;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [18:0] addr = 19'd0;
    logic [7:0]  wdata = 8'd0;
    logic        rdy, resp;
    logic [7:0]  rdata;
    logic        sram_ce_bar, sram_oe_bar, sram_we_bar, sram_data_dir;
    logic [7:0]  sram_data_out;
    logic [7:0]  sram_data_in = 8'd0;
    logic [18:0] sram_addr;

    sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdy(rdy), .resp(resp), .rdata(rdata),
        .sram_ce_bar(sram_ce_bar), .sram_oe_bar(sram_oe_bar), .sram_we_bar(sram_we_bar),
        .sram_data_dir(sram_data_dir), .sram_data_out(sram_data_out),
        .sram_data_in(sram_data_in), .sram_addr(sram_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cnt = 0;
    int txn_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural SRAM contents
    logic [7:0] mem [logic [18:0]];

    // Scoreboard of outstanding accesses
    typedef struct {
        logic        w;
        logic [18:0] a;
        int          resp_cyc;
        logic [7:0]  exp_rd;
    } sb_t;
    sb_t sb[$];

    // Pin model state for the most recent accepted access
    bit          acc_valid = 0;
    int          acc_cyc = 0;
    logic        acc_we = 1'b0;
    logic [18:0] acc_addr = 19'd0;
    logic [7:0]  acc_wdata = 8'd0;
    logic [7:0]  last_rd = 8'd0;

    task automatic note_accept(input logic w, input logic [18:0] a, input logic [7:0] d,
                               input logic [7:0] exp_rd);
        sb_t e;
        acc_valid = 1;
        acc_cyc   = cyc;
        acc_we    = w;
        acc_addr  = a;
        acc_wdata = d;
        e.w = w;
        e.a = a;
        e.resp_cyc = cyc + 2 + (w ? WR_WAIT : RD_WAIT);
        if (!w) last_rd = exp_rd;
        e.exp_rd = last_rd;
        sb.push_back(e);
    endtask

    // Per-cycle pin model, invariants, scoreboard pop and SRAM model
    int   k, wt;
    logic e_ce, e_oe, e_we, e_dir, e_rdy, e_resp;
    logic prev_we = 1'b1, prev_oe = 1'b1, prev_ce = 1'b1;

    always @(negedge clk) begin
        if (rstn) begin
            e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1; e_dir = DIR_IN; e_rdy = 1'b1; e_resp = 1'b0;
            if (acc_valid) begin
                k  = cyc - acc_cyc;
                wt = acc_we ? WR_WAIT : RD_WAIT;
                if (k >= 1 && k <= 2 + wt + TURN) e_rdy = 1'b0;
                if (k >= 1 && k <= 2 + wt) begin
                    e_ce  = 1'b0;
                    e_dir = acc_we ? DIR_OUT : DIR_IN;
                    check("sram_addr", 32'(sram_addr), 32'(acc_addr));
                    if (acc_we) check("sram_data_out", 32'(sram_data_out), 32'(acc_wdata));
                end
                if (k >= 2 && k <= 1 + wt) begin
                    if (acc_we) e_we = 1'b0;
                    else        e_oe = 1'b0;
                end
                if (k == 2 + wt) e_resp = 1'b1;
            end
            check("ce_bar", 32'(sram_ce_bar), 32'(e_ce));
            check("oe_bar", 32'(sram_oe_bar), 32'(e_oe));
            check("we_bar", 32'(sram_we_bar), 32'(e_we));
            check("data_dir", 32'(sram_data_dir), 32'(e_dir));
            check("rdy", 32'(rdy), 32'(e_rdy));
            check("resp", 32'(resp), 32'(e_resp));
            check("inv_oe_while_out", 32'(!sram_oe_bar && sram_data_dir == DIR_OUT), 32'(0));
            check("inv_oe_and_we", 32'(!sram_oe_bar && !sram_we_bar), 32'(0));
            if ((prev_oe && !sram_oe_bar) || (prev_we && !sram_we_bar))
                check("inv_strobe_before_ce", 32'(prev_ce), 32'(0));
            if (resp) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    check("resp_unexpected", 32'(1), 32'(0));
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    txn_no++;
                    $display("txn %0d: %s addr=0x%05h rdata=0x%02h resp_cycle=%0d", txn_no,
                             e.w ? "write" : "read ", e.a, rdata, cyc);
                    check("resp_cycle", 32'(cyc), 32'(e.resp_cyc));
                    check("rdata", 32'(rdata), 32'(e.exp_rd));
                end
            end
        end
        // SRAM model: writes land on WE# rising while CE# is low
        if (!prev_we && sram_we_bar && !sram_ce_bar) mem[sram_addr] = sram_data_out;
        if (!sram_oe_bar && !sram_ce_bar)
            sram_data_in = mem.exists(sram_addr) ? mem[sram_addr] : 8'hEE;
        else
            sram_data_in = 8'h00;
        prev_we = sram_we_bar;
        prev_oe = sram_oe_bar;
        prev_ce = sram_ce_bar;
    end

    // Called at posedge+1; drives a request and waits (bounded) for acceptance
    task automatic start_txn(input logic w, input logic [18:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd, input bit keep_req);
        bit ok;
        ok = 0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        check("accept_seen", 32'(ok), 32'(1));
        if (ok) note_accept(w, a, d, exp_rd);
        @(posedge clk); #1;
        if (!keep_req) begin
            req = 1'b0;
            we = 1'($urandom);
            addr = 19'($urandom);
            wdata = 8'($urandom);
        end
    endtask

    // Waits (bounded) until idle with nothing outstanding; ends at posedge+1
    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rdy && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("idle_reached", 32'(ok), 32'(1));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        w;
        logic [18:0] a;
        logic [7:0]  d;
        logic        pre;
        logic [7:0]  pre_val;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[8];

    int t0, r0;

    initial begin
        vecs[0] = '{1'b0, 19'h12345, 8'h00, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 19'h7FFFF, 8'h3C, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 19'h7FFFF, 8'h00, 1'b0, 8'h00, 8'h3C};
        vecs[3] = '{1'b1, 19'h00000, 8'h5A, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 19'h00000, 8'h00, 1'b0, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 19'h40001, 8'h00, 1'b1, 8'h81, 8'h81};
        vecs[6] = '{1'b1, 19'h12345, 8'hC3, 1'b0, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 19'h12345, 8'h00, 1'b0, 8'h00, 8'hC3};

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(rdy), 32'(1));
        check("rst_ce_bar", 32'(sram_ce_bar), 32'(1));
        check("rst_oe_bar", 32'(sram_oe_bar), 32'(1));
        check("rst_we_bar", 32'(sram_we_bar), 32'(1));
        check("rst_dir", 32'(sram_data_dir), 32'(DIR_IN));
        check("rst_resp", 32'(resp), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_addr", 32'(sram_addr), 32'(0));
        check("rst_data_out", 32'(sram_data_out), 32'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pre) mem[vecs[i].a] = vecs[i].pre_val;
            start_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp, 0);
            wait_idle();
        end

        // Write then read with req held high across completion
        start_txn(1'b1, 19'h2AAAA, 8'h69, 8'h00, 1);
        t0 = acc_cyc;
        start_txn(1'b0, 19'h2AAAA, 8'h00, 8'h69, 0);
        check("b2b_accept_gap", 32'(acc_cyc - t0), 32'(3 + WR_WAIT + TURN));
        wait_idle();

        // req pulsed while busy must be ignored
        mem[19'h01234] = 8'h96;
        r0 = resp_cnt;
        start_txn(1'b0, 19'h01234, 8'h00, 8'h96, 0);
        req = 1'b1; we = 1'b1; addr = 19'h55555; wdata = 8'hFF;
        @(posedge clk); #1;
        req = 1'b0;
        wait_idle();
        check("busy_pulse_resp_count", 32'(resp_cnt - r0), 32'(1));

        // Reset during the second ACCESS cycle of a write
        mem[19'h0AAAA] = 8'h11;
        start_txn(1'b1, 19'h0AAAA, 8'h77, 8'h00, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("midrst_we_low_before", 32'(sram_we_bar), 32'(0));
        rstn = 1'b0;
        sb.delete();
        acc_valid = 0;
        last_rd = 8'h00;
        r0 = resp_cnt;
        #1;
        check("midrst_we_bar", 32'(sram_we_bar), 32'(1));
        check("midrst_ce_bar", 32'(sram_ce_bar), 32'(1));
        check("midrst_dir", 32'(sram_data_dir), 32'(DIR_IN));
        check("midrst_rdy", 32'(rdy), 32'(1));
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_resp", 32'(resp), 32'(0));
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        start_txn(1'b0, 19'h0AAAA, 8'h00, 8'h11, 0);
        wait_idle();
        check("midrst_one_resp_after", 32'(resp_cnt - r0), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
